// File: rtl/xvga_timing.sv
// xvga_timing: video timing generator, 1024x768 @ 60 Hz by default.
//
// Ports:
//   clk          pixel clock (65 MHz)
//   reset        synchronous, active-high
//   hcount[10:0] pixel index within line, 0..H_TOTAL-1
//   vcount[9:0]  line index within frame, 0..V_TOTAL-1
//   hsync        horizontal sync, asserted level HSYNC_POL
//   vsync        vertical sync, asserted level VSYNC_POL
//   blank        high outside the visible region
//   new_line     one-cycle strobe when hcount wraps to 0
//   new_frame    one-cycle strobe when (hcount,vcount) wraps to (0,0)
//   frame_count  completed-frame counter, wraps 16'hFFFF -> 0
//
// Every output is a flop loaded from the next-state counter values, so the
// (hcount, vcount, sync, blank, strobe) tuple always describes one pixel.
// H_TOTAL must be <= 2048 and V_TOTAL <= 1024 (counter widths are fixed).
// FRAME_COUNT_INIT is a test hook for exercising the counter wrap; leave at 0.
module xvga_timing #(
  parameter int          H_ACTIVE         = 1024,
  parameter int          H_FP             = 24,
  parameter int          H_SYNC           = 136,
  parameter int          H_BP             = 160,
  parameter int          V_ACTIVE         = 768,
  parameter int          V_FP             = 3,
  parameter int          V_SYNC           = 6,
  parameter int          V_BP             = 29,
  parameter logic        HSYNC_POL        = 1'b0,
  parameter logic        VSYNC_POL        = 1'b0,
  parameter logic [15:0] FRAME_COUNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        new_line,
  output logic        new_frame,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        h_last, v_last, wrap_line, wrap_frame;
  logic [10:0] h_nxt;
  logic [9:0]  v_nxt;
  logic        hsync_nxt, vsync_nxt, blank_nxt;

  // Next-state counters and the flags derived from them.
  always_comb begin
    h_last     = (hcount == H_LAST);
    v_last     = (vcount == V_LAST);
    wrap_line  = h_last;
    wrap_frame = h_last && v_last;

    h_nxt = hcount + 11'd1;
    v_nxt = vcount;
    if (h_last) begin
      h_nxt = '0;
      v_nxt = v_last ? '0 : vcount + 10'd1;
    end

    hsync_nxt = ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
    // vsync depends only on the line, so its edges land on hcount==0 cycles.
    vsync_nxt = ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
    blank_nxt = (h_nxt >= H_VIS) || (v_nxt >= V_VIS);
  end

  // Reset forces blank low and strobes off even though (0,0) is a visible
  // pixel: strobes only ever come from a real counter wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      blank       <= 1'b0;
      new_line    <= 1'b0;
      new_frame   <= 1'b0;
      frame_count <= FRAME_COUNT_INIT;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      blank       <= blank_nxt;
      new_line    <= wrap_line;
      new_frame   <= wrap_frame;
      if (wrap_frame)
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_xvga_timing.sv
// Self-checking bench for xvga_timing. A shrunken timing instance (25x13
// frame) covers whole-frame behaviour, a second shrunken instance starts its
// frame counter near the top to cover the wrap, and a default-parameter
// instance covers the first 1024x768 line.
module tb_xvga_timing;

  // Small timing: H 16+2+4+3 = 25, hsync 18..21; V 8+1+2+2 = 13, vsync 9..10.
  localparam int SH = 25;
  localparam int SV = 13;
  localparam int SF = SH * SV;   // 325

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [10:0] s_hc, w_hc, d_hc;
  logic [9:0]  s_vc, w_vc, d_vc;
  logic        s_hs, s_vs, s_bl, s_nl, s_nf;
  logic        w_hs, w_vs, w_bl, w_nl, w_nf;
  logic        d_hs, d_vs, d_bl, d_nl, d_nf;
  logic [15:0] s_fc, w_fc, d_fc;

  xvga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_small (
    .clk(clk), .reset(reset), .hcount(s_hc), .vcount(s_vc), .hsync(s_hs),
    .vsync(s_vs), .blank(s_bl), .new_line(s_nl), .new_frame(s_nf),
    .frame_count(s_fc)
  );

  xvga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .FRAME_COUNT_INIT(16'hFFFE)
  ) u_wrap (
    .clk(clk), .reset(reset), .hcount(w_hc), .vcount(w_vc), .hsync(w_hs),
    .vsync(w_vs), .blank(w_bl), .new_line(w_nl), .new_frame(w_nf),
    .frame_count(w_fc)
  );

  xvga_timing u_dflt (
    .clk(clk), .reset(reset), .hcount(d_hc), .vcount(d_vc), .hsync(d_hs),
    .vsync(d_vs), .blank(d_bl), .new_line(d_nl), .new_frame(d_nf),
    .frame_count(d_fc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    int p, h, v;
    int hs_lo, vs_lo, vis, d_hs_lo, d_hs_rise, d_hs_fall, d_nl_cnt;
    int nf_cnt, last_nf, guard;
    logic prev_d_hs;
    hs_lo = 0; vs_lo = 0; vis = 0; d_hs_lo = 0; d_hs_rise = 0; d_hs_fall = 0;
    d_nl_cnt = 0; nf_cnt = 0; last_nf = 0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hc",  32'(s_hc), 0);
    chk("rst_vc",  32'(s_vc), 0);
    chk("rst_hs",  32'(s_hs), 1);
    chk("rst_vs",  32'(s_vs), 1);
    chk("rst_bl",  32'(s_bl), 0);
    chk("rst_nl",  32'(s_nl), 0);
    chk("rst_nf",  32'(s_nf), 0);
    chk("rst_fc",  32'(s_fc), 0);
    chk("rst_wfc", 32'(w_fc), 32'hFFFE);
    chk("rst_dhs", 32'(d_hs), 1);
    prev_d_hs = d_hs;

    reset = 1'b0;
    // k = number of posedges since release; position within frame is k mod SF.
    for (int k = 1; k <= 1400; k++) begin
      @(posedge clk);
      #1;
      p = k % SF;
      h = p % SH;
      v = p / SH;
      chk("s_hc", 32'(s_hc), 32'(h));
      chk("s_vc", 32'(s_vc), 32'(v));
      chk("s_hs", 32'(s_hs), (h >= 18 && h <= 21) ? 0 : 1);
      chk("s_vs", 32'(s_vs), (v >= 9 && v <= 10) ? 0 : 1);
      chk("s_bl", 32'(s_bl), (h >= 16 || v >= 8) ? 1 : 0);
      chk("s_nl", 32'(s_nl), (h == 0) ? 1 : 0);
      chk("s_nf", 32'(s_nf), (p == 0) ? 1 : 0);
      chk("s_fc", 32'(s_fc), 32'(k / SF));
      chk("w_fc", 32'(w_fc), 32'(16'(32'hFFFE + k / SF)));

      if (k <= SF) begin
        if (!s_hs) hs_lo++;
        if (!s_vs) vs_lo++;
        if (!s_bl) vis++;
      end
      if (s_nf) begin
        nf_cnt++;
        if (last_nf != 0) chk("nf_spacing", 32'(k - last_nf), 32'(SF));
        chk("fc_at_nf", 32'(s_fc), 32'(nf_cnt));
        last_nf = k;
      end

      // Default 1344-pixel line: first line only.
      if (k <= 1344) begin
        chk("d_hc", 32'(d_hc), 32'(k % 1344));
        chk("d_vc", 32'(d_vc), 32'(k / 1344));
        chk("d_hs", 32'(d_hs), (k >= 1048 && k <= 1183) ? 0 : 1);
        chk("d_bl", 32'(d_bl), (k >= 1024 && k < 1344) ? 1 : 0);
        chk("d_nf", 32'(d_nf), 0);
        if (!d_hs) d_hs_lo++;
        if (prev_d_hs && !d_hs) d_hs_fall = k;
        if (!prev_d_hs && d_hs) d_hs_rise = k;
        if (d_nl) d_nl_cnt++;
        prev_d_hs = d_hs;
      end
    end

    chk("s_hs_lo_frame", 32'(hs_lo), 32'(SV * 4));
    chk("s_vs_lo_frame", 32'(vs_lo), 32'(2 * SH));
    chk("s_visible",     32'(vis),   32'(16 * 8));
    chk("nf_pulses",     32'(nf_cnt), 4);
    chk("d_hs_lo_line",  32'(d_hs_lo), 136);
    chk("d_hs_assert",   32'(d_hs_fall), 1048);
    chk("d_hs_deassert", 32'(d_hs_rise), 1184);
    chk("d_nl_count",    32'(d_nl_cnt), 1);

    // Mid-frame reset inside both sync pulses: (19,10).
    guard = 0;
    while (!(s_hc == 11'd19 && s_vc == 10'd10) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("reach_19_10", (guard < 500) ? 1 : 0, 1);
    chk("pre_rst_hs", 32'(s_hs), 0);
    chk("pre_rst_vs", 32'(s_vs), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_hc", 32'(s_hc), 0);
    chk("mid_vc", 32'(s_vc), 0);
    chk("mid_hs", 32'(s_hs), 1);
    chk("mid_vs", 32'(s_vs), 1);
    chk("mid_bl", 32'(s_bl), 0);
    chk("mid_nl", 32'(s_nl), 0);
    chk("mid_nf", 32'(s_nf), 0);
    chk("mid_fc", 32'(s_fc), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("resume_hc", 32'(s_hc), 1);
    chk("resume_vc", 32'(s_vc), 0);
    chk("resume_nl", 32'(s_nl), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
